seven_segment_scheduler: RTL and testbench

Time-shares the 32-bit value input of the eight-digit seven-segment controller between `NUM_SRC` independent requesters. Each requester offers a value through a valid/ready handshake. The scheduler grants sources in round-robin order and holds each granted value on the display for a minimum dwell time before the next grant. It sits between the system's status producers and the display controller's value input.

---
 rtl/seven_segment_pkg.sv | 12 +
 rtl/seven_segment_scheduler_rr_arbiter.sv | 34 +++
 rtl/seven_segment_scheduler.sv | 86 ++++++++
 tb/tb_seven_segment_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment display path: the value width
// used by the display controller and the scheduler state encoding.
package seven_segment_pkg;

    localparam int VALUE_W = 32;

    typedef enum logic {
        OPEN  = 1'b0,
        DWELL = 1'b1
    } sched_state_e;

endpackage

// File: rtl/seven_segment_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter. Picks the first requester strictly
// after ptr, wrapping modulo N. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IDX_W = $clog2(N);

    logic             found;
    logic [IDX_W-1:0] idx;

    // Scan from ptr+1 around to ptr itself; the first asserted request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IDX_W'((int'(ptr) + i) % N);
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

endmodule

// File: rtl/seven_segment_scheduler.sv
// Time-shares the display value between NUM_SRC requesters. Grants are
// round-robin, and each granted value is held for at least DWELL_CYCLES
// cycles before another grant is possible. freeze_i stalls the countdown
// and blocks grants.
module seven_segment_scheduler
    import seven_segment_pkg::*;
#(
    parameter int          NUM_SRC      = 4,
    parameter int          DWELL_CYCLES = 50_000_000,
    parameter logic [31:0] RESET_VALUE  = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_SRC-1:0]         src_valid_i,
    input  logic [NUM_SRC*32-1:0]      src_value_i,
    output logic [NUM_SRC-1:0]         src_ready_o,
    input  logic                       freeze_i,
    output logic [31:0]                value_o,
    output logic [$clog2(NUM_SRC)-1:0] active_src_o,
    output logic                       active_valid_o
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(DWELL_CYCLES);

    sched_state_e       state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic               grant_allowed;
    logic               transfer;
    logic [VALUE_W-1:0] sel_value;

    // cnt is zero whenever the dwell has expired, so DWELL with cnt==0
    // behaves like OPEN for granting purposes.
    assign grant_allowed = !freeze_i && ((state == OPEN) || (cnt == '0));

    rr_arbiter #(
        .N (NUM_SRC)
    ) u_arb (
        .req     (src_valid_i),
        .ptr     (ptr),
        .en      (grant_allowed),
        .gnt     (src_ready_o),
        .gnt_idx (gnt_idx)
    );

    assign transfer = |(src_valid_i & src_ready_o);

    // Value mux driven by the arbiter's binary grant index.
    always_comb begin
        sel_value = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (gnt_idx == IDX_W'(k)) begin
                sel_value = src_value_i[k*VALUE_W +: VALUE_W];
            end
        end
    end

    // State, dwell countdown, round-robin pointer and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= OPEN;
            cnt            <= '0;
            ptr            <= IDX_W'(NUM_SRC - 1);
            value_o        <= RESET_VALUE;
            active_src_o   <= '0;
            active_valid_o <= 1'b0;
        end else if (transfer) begin
            value_o        <= sel_value;
            active_src_o   <= gnt_idx;
            ptr            <= gnt_idx;
            active_valid_o <= 1'b1;
            cnt            <= CNT_W'(DWELL_CYCLES - 1);
            state          <= DWELL;
        end else if ((state == DWELL) && !freeze_i) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                // Dwell over and nobody asking: go idle, keep showing the value.
                state <= OPEN;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scheduler.sv
// Directed bench for seven_segment_scheduler with NUM_SRC=4, DWELL_CYCLES=4.
module tb_seven_segment_scheduler;

    localparam int NUM_SRC = 4;
    localparam int DWELL   = 4;

    logic                  clk = 1'b0;
    logic                  rst_ni;
    logic [NUM_SRC-1:0]    src_valid;
    logic [NUM_SRC*32-1:0] src_value;
    logic [NUM_SRC-1:0]    src_ready;
    logic                  freeze;
    logic [31:0]           value;
    logic [1:0]            active_src;
    logic                  active_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_val;
    logic [3:0]  exp_rdy;

    always #5 clk = ~clk;

    seven_segment_scheduler #(
        .NUM_SRC      (NUM_SRC),
        .DWELL_CYCLES (DWELL),
        .RESET_VALUE  (32'h0000_0000)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .src_valid_i    (src_valid),
        .src_value_i    (src_value),
        .src_ready_o    (src_ready),
        .freeze_i       (freeze),
        .value_o        (value),
        .active_src_o   (active_src),
        .active_valid_o (active_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int k, input logic [31:0] v);
        src_value[k*32 +: 32] = v;
    endtask

    initial begin
        rst_ni    = 1'b0;
        src_valid = '0;
        src_value = '0;
        freeze    = 1'b0;

        // Reset
        repeat (3) tick();
        check("rst_value", value, 32'h0);
        check("rst_avalid", {31'b0, active_valid}, 32'h0);
        check("rst_asrc", {30'b0, active_src}, 32'h0);
        check("rst_ready", {28'b0, src_ready}, 32'h0);
        rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("idle_ready", {28'b0, src_ready}, 32'h0);
            tick();
            check("idle_value", value, 32'h0);
            check("idle_avalid", {31'b0, active_valid}, 32'h0);
        end

        // Single source: source 2 in OPEN is granted the same cycle
        set_src(2, 32'hFDEC_BA98);
        src_valid = 4'b0100;
        #1;
        check("single_ready_T", {28'b0, src_ready}, 32'h4);
        tick();
        check("single_value", value, 32'hFDEC_BA98);
        check("single_asrc", {30'b0, active_src}, 32'h2);
        check("single_avalid", {31'b0, active_valid}, 32'h1);
        for (int i = 1; i <= 3; i++) begin
            #1;
            check("single_noready", {28'b0, src_ready}, 32'h0);
            tick();
        end
        src_valid = '0;
        repeat (2) tick();

        // Round-robin: reset so the pointer restarts before source 0
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) set_src(k, 32'(32'h1111_1111 * (k + 1)));
        src_valid = 4'b1111;
        exp_val   = 32'h0;
        for (int j = 0; j <= 16; j++) begin
            exp_rdy = (j % 4 == 0) ? 4'(1 << ((j / 4) % 4)) : 4'b0000;
            #1;
            check("rr_ready", {28'b0, src_ready}, {28'b0, exp_rdy});
            tick();
            if (exp_rdy != 4'b0000) exp_val = 32'(32'h1111_1111 * (((j / 4) % 4) + 1));
            check("rr_value", value, exp_val);
        end
        check("rr_asrc_last", {30'b0, active_src}, 32'h0);

        // Let the last dwell expire into OPEN
        src_valid = '0;
        repeat (5) tick();

        // Freeze: grant at T, freeze T+2..T+4 pushes next grant to T+7
        set_src(1, 32'hA5A5_0001);
        src_valid = 4'b0010;
        #1;
        check("frz_ready_T", {28'b0, src_ready}, 32'h2);
        tick();
        set_src(1, 32'h5A5A_0002);
        #1;
        check("frz_ready_T1", {28'b0, src_ready}, 32'h0);
        check("frz_value_A", value, 32'hA5A5_0001);
        tick();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("frz_ready_frozen", {28'b0, src_ready}, 32'h0);
            tick();
        end
        freeze = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("frz_ready_count", {28'b0, src_ready}, 32'h0);
            check("frz_value_hold", value, 32'hA5A5_0001);
            tick();
        end
        // T+7 would be a grant; freezing it suppresses ready
        freeze = 1'b1;
        #1;
        check("frz_suppress", {28'b0, src_ready}, 32'h0);
        tick();
        freeze = 1'b0;
        #1;
        check("frz_regrant", {28'b0, src_ready}, 32'h2);
        tick();
        check("frz_value_B", value, 32'h5A5A_0002);
        check("frz_asrc", {30'b0, active_src}, 32'h1);

        // Idle hold
        src_valid = '0;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("hold_ready", {28'b0, src_ready}, 32'h0);
            check("hold_value", value, 32'h5A5A_0002);
            tick();
        end
        // OPEN: a new request is granted with zero wait
        set_src(2, 32'hC0DE_0003);
        src_valid = 4'b0100;
        #1;
        check("open_zero_wait", {28'b0, src_ready}, 32'h4);
        tick();
        // Withdraw: source 1 asks during DWELL and gives up before cnt==0
        src_valid = 4'b0010;
        set_src(1, 32'hDEAD_BEEF);
        #1;
        check("wd_ready_1", {28'b0, src_ready}, 32'h0);
        tick();
        #1;
        check("wd_ready_2", {28'b0, src_ready}, 32'h0);
        src_valid = '0;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wd_ready_after", {28'b0, src_ready}, 32'h0);
            tick();
        end
        check("wd_value", value, 32'hC0DE_0003);
        check("wd_asrc", {30'b0, active_src}, 32'h2);

        // Reset mid-dwell
        set_src(3, 32'h0BAD_F00D);
        src_valid = 4'b1000;
        #1;
        check("mid_ready", {28'b0, src_ready}, 32'h8);
        tick();
        src_valid = '0;
        check("mid_value", value, 32'h0BAD_F00D);
        check("mid_avalid", {31'b0, active_valid}, 32'h1);
        tick();
        rst_ni = 1'b0;
        #1;
        check("mid_rst_value", value, 32'h0);
        check("mid_rst_avalid", {31'b0, active_valid}, 32'h0);
        check("mid_rst_asrc", {30'b0, active_src}, 32'h0);
        tick();
        rst_ni    = 1'b1;
        src_valid = 4'b1111;
        #1;
        check("post_rst_ready", {28'b0, src_ready}, 32'h1);
        tick();
        check("post_rst_value", value, 32'h1111_1111);
        check("post_rst_asrc", {30'b0, active_src}, 32'h0);
        check("post_rst_avalid", {31'b0, active_valid}, 32'h1);
        src_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
